// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: AES-128 control FSM that owns the state register and steps it through
// the external SubBytes/ShiftRows/MixColumns/AddRoundKey stages. Stage watchdog: AES_SEQ_TIMEOUT_EN.
//
//  state  | meaning
//  IDLE   | waiting for start, outputs at reset values
//  CLR    | one-cycle clear pulse to the stage about to run
//  RUN    | selected stage enabled until its done bit is seen
//  DONE   | ciphertext held on dout, new start accepted
module aes_round_sequencer #(
  parameter int W  = 128,
  parameter int NR = 10
`ifdef AES_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] din,
  input  logic [W-1:0] rk,
  output logic [3:0]   rk_idx,
  output logic [W-1:0] stg_in,
  output logic         stg_clr,
  output logic [3:0]   stg_en,
  input  logic [3:0]   stg_done,
  input  logic [W-1:0] sb_out,
  input  logic [W-1:0] sr_out,
  input  logic [W-1:0] mc_out,
  input  logic [W-1:0] ark_out,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] dout,
  output logic         err
);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DONE} fsm_t;
  typedef enum logic [1:0] {
    STG_SB  = 2'd0,
    STG_SR  = 2'd1,
    STG_MC  = 2'd2,
    STG_ARK = 2'd3
  } stage_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  fsm_t         fsm;
  stage_t       cur_stage;
  stage_t       nxt_stage;
  logic [3:0]   round;
  logic [W-1:0] state_q;
  logic [W-1:0] stage_result;
  logic         stage_hit;
  logic         last_capture;
  logic         unused_rk;

  // rk is consumed by the external AddRoundKey stage; only its index is generated here.
  assign unused_rk    = ^rk;
  assign rk_idx       = round;
  assign stg_in       = state_q;
  assign dout         = state_q;
  assign stage_hit    = stg_done[cur_stage];
  assign last_capture = (cur_stage == STG_ARK) && (round == LAST_ROUND);

  // Final round has no MixColumns: ShiftRows hands straight to AddRoundKey.
  always_comb begin
    stage_result = ark_out;
    nxt_stage    = STG_SB;
    case (cur_stage)
      STG_SB: begin
        stage_result = sb_out;
        nxt_stage    = STG_SR;
      end
      STG_SR: begin
        stage_result = sr_out;
        nxt_stage    = (round == LAST_ROUND) ? STG_ARK : STG_MC;
      end
      STG_MC: begin
        stage_result = mc_out;
        nxt_stage    = STG_ARK;
      end
      default: begin
        stage_result = ark_out;
        nxt_stage    = STG_SB;
      end
    endcase
  end

`ifdef AES_SEQ_TIMEOUT_EN
  localparam logic [3:0] TMO_LOAD = 4'(TIMEOUT - 1);
  logic [3:0] tmo_cnt;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= S_IDLE;
      cur_stage <= STG_ARK;
      round     <= '0;
      state_q   <= '0;
      stg_en    <= '0;
      stg_clr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
      tmo_cnt   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (fsm)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= din;
            round     <= '0;
            cur_stage <= STG_ARK;
            busy      <= 1'b1;
            done      <= 1'b0;
            stg_clr   <= 1'b1;
            stg_en    <= '0;
            fsm       <= S_CLR;
`ifdef AES_SEQ_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end
        end
        S_CLR: begin
          stg_clr <= 1'b0;
          stg_en  <= 4'b0001 << cur_stage;
          fsm     <= S_RUN;
`ifdef AES_SEQ_TIMEOUT_EN
          tmo_cnt <= TMO_LOAD;
`endif
        end
        S_RUN: begin
          if (stage_hit) begin
            state_q <= stage_result;
            stg_en  <= '0;
            if (last_capture) begin
              busy <= 1'b0;
              done <= 1'b1;
              fsm  <= S_DONE;
            end else begin
              if (cur_stage == STG_ARK) round <= round + 4'd1;
              cur_stage <= nxt_stage;
              stg_clr   <= 1'b1;
              fsm       <= S_CLR;
            end
          end
`ifdef AES_SEQ_TIMEOUT_EN
          // Watchdog: down-counter reaching zero means the stage used its whole budget.
          else if (tmo_cnt == '0) begin
            err_q  <= 1'b1;
            stg_en <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            fsm    <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt - 4'd1;
          end
`endif
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule
